// File: rtl/sync_control.sv
// PCS receive synchronization FSM: aligns code-group parity to K28.5 commas,
// declares/withdraws link sync and forwards tagged code-groups on sudi.
module sync_control #(
  parameter int CG_WIDTH     = 10,
  parameter int GOOD_CGS_MAX = 3
) (
  input  logic                rx_clk,
  input  logic                mr_main_reset,
  input  logic [CG_WIDTH-1:0] code_group_in,
  input  logic                cg_invalid,
  input  logic                signal_detect,
  output logic [CG_WIDTH:0]   sudi,
  output logic                sync_status,
  output logic [3:0]          sync_state
);

  typedef enum logic [3:0] {
    ST_LOS  = 4'd0,
    ST_CD1  = 4'd1,
    ST_AS1  = 4'd2,
    ST_CD2  = 4'd3,
    ST_AS2  = 4'd4,
    ST_CD3  = 4'd5,
    ST_SA1  = 4'd6,
    ST_SA2  = 4'd7,
    ST_SA2A = 4'd8,
    ST_SA3  = 4'd9,
    ST_SA3A = 4'd10,
    ST_SA4  = 4'd11,
    ST_SA4A = 4'd12
  } state_t;

  localparam logic [1:0] GOOD_MAX_C = 2'(GOOD_CGS_MAX);

  // K28.5 in either running disparity
  function automatic logic is_comma(input logic [CG_WIDTH-1:0] cg);
    return (cg == 10'b0011111010) || (cg == 10'b1100000101);
  endfunction

  function automatic logic is_sync_state(input state_t st);
    return (st == ST_SA1)  || (st == ST_SA2)  || (st == ST_SA2A) ||
           (st == ST_SA3)  || (st == ST_SA3A) || (st == ST_SA4)  ||
           (st == ST_SA4A);
  endfunction

  state_t              state_r;
  state_t              fsm_nxt_s;
  state_t              state_nxt_s;
  logic                rx_even_r;
  logic                rx_even_nxt_s;
  logic [1:0]          good_cgs_r;
  logic [1:0]          good_cgs_nxt_s;
  logic [CG_WIDTH:0]   sudi_r;
  logic                sync_status_r;
  logic                comma_s;
  logic                cgbad_s;
  logic                good_max_s;

  // Code-group classification against the current parity
  always_comb begin
    comma_s    = is_comma(code_group_in);
    cgbad_s    = cg_invalid | (comma_s & rx_even_r);
    good_max_s = (good_cgs_r == GOOD_MAX_C);
  end

  // Next-state logic; loss of signal overrides every transition
  always_comb begin
    fsm_nxt_s = ST_LOS;
    case (state_r)
      ST_LOS:  fsm_nxt_s = comma_s ? ST_CD1 : ST_LOS;
      ST_CD1:  fsm_nxt_s = (!comma_s && !cg_invalid) ? ST_AS1 : ST_LOS;
      ST_CD2:  fsm_nxt_s = (!comma_s && !cg_invalid) ? ST_AS2 : ST_LOS;
      ST_CD3:  fsm_nxt_s = (!comma_s && !cg_invalid) ? ST_SA1 : ST_LOS;
      ST_AS1: begin
        if (cgbad_s)                      fsm_nxt_s = ST_LOS;
        else if (comma_s && !rx_even_r)   fsm_nxt_s = ST_CD2;
        else                              fsm_nxt_s = ST_AS1;
      end
      ST_AS2: begin
        if (cgbad_s)                      fsm_nxt_s = ST_LOS;
        else if (comma_s && !rx_even_r)   fsm_nxt_s = ST_CD3;
        else                              fsm_nxt_s = ST_AS2;
      end
      ST_SA1:  fsm_nxt_s = cgbad_s ? ST_SA2 : ST_SA1;
      ST_SA2:  fsm_nxt_s = cgbad_s ? ST_SA3 : ST_SA2A;
      ST_SA3:  fsm_nxt_s = cgbad_s ? ST_SA4 : ST_SA3A;
      ST_SA4:  fsm_nxt_s = cgbad_s ? ST_LOS : ST_SA4A;
      ST_SA2A: begin
        if (cgbad_s)         fsm_nxt_s = ST_SA3;
        else if (good_max_s) fsm_nxt_s = ST_SA1;
        else                 fsm_nxt_s = ST_SA2A;
      end
      ST_SA3A: begin
        if (cgbad_s)         fsm_nxt_s = ST_SA4;
        else if (good_max_s) fsm_nxt_s = ST_SA2;
        else                 fsm_nxt_s = ST_SA3A;
      end
      ST_SA4A: begin
        if (cgbad_s)         fsm_nxt_s = ST_LOS;
        else if (good_max_s) fsm_nxt_s = ST_SA3;
        else                 fsm_nxt_s = ST_SA4A;
      end
      default: fsm_nxt_s = ST_LOS;
    endcase
    if (signal_detect) begin
      state_nxt_s = fsm_nxt_s;
    end else begin
      state_nxt_s = ST_LOS;
    end
  end

  // Parity tag and good-code-group counter for the state being entered
  always_comb begin
    rx_even_nxt_s  = ~rx_even_r;
    good_cgs_nxt_s = good_cgs_r;
    case (state_nxt_s)
      ST_CD1, ST_CD2, ST_CD3: rx_even_nxt_s = 1'b1;
      default:                rx_even_nxt_s = ~rx_even_r;
    endcase
    case (state_nxt_s)
      ST_SA2, ST_SA3:            good_cgs_nxt_s = 2'd0;
      ST_SA2A, ST_SA3A, ST_SA4A: good_cgs_nxt_s = (good_cgs_r == 2'd3) ? 2'd3 : good_cgs_r + 2'd1;
      default:                   good_cgs_nxt_s = good_cgs_r;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge rx_clk) begin
    if (!mr_main_reset) begin
      state_r       <= ST_LOS;
      rx_even_r     <= 1'b0;
      good_cgs_r    <= 2'd0;
      sudi_r        <= '0;
      sync_status_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rx_even_r     <= rx_even_nxt_s;
      good_cgs_r    <= good_cgs_nxt_s;
      sudi_r        <= {code_group_in, rx_even_nxt_s};
      sync_status_r <= is_sync_state(state_nxt_s);
    end
  end

  assign sudi        = sudi_r;
  assign sync_status = sync_status_r;
  assign sync_state  = state_r;

endmodule
